pc_fetch_register: RTL and testbench

//  Program-counter register for the single-cycle CPU labs; it drives fetch addresses into instruction memory.

---
 rtl/pc_fetch_register_pkg.sv | 14 +
 rtl/pc_fetch_register_next_calc.sv | 33 +++
 rtl/pc_fetch_register.sv | 94 +++++++++
 tb/tb_pc_fetch_register.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_register_pkg.sv
// Shared definitions for the PC fetch register: FSM state encoding and default parameters.
package pc_fetch_register_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_STEP     = 4;

endpackage

// File: rtl/pc_fetch_register_next_calc.sv
// Combinational next-PC selection: aligned redirect, sequential advance on transfer, or hold.
module pc_next_calc
    import pc_fetch_register_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = DEFAULT_STEP
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             transfer,
    output logic [WIDTH-1:0] next_pc,
    output logic             misaligned
);

    // STEP is a power of two, so alignment is a test of the low address bits
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    logic target_unaligned;

    assign target_unaligned = |(redirect_target & ALIGN_MASK);
    assign misaligned       = redirect_valid & target_unaligned;

    always_comb begin
        next_pc = pc;
        if (redirect_valid && !target_unaligned) begin
            next_pc = redirect_target;
        end else if (transfer) begin
            next_pc = pc + WIDTH'(STEP);
        end
    end

endmodule

// File: rtl/pc_fetch_register.sv
// Program-counter register issuing fetch addresses over a valid/ready channel,
// with redirect, stall, misaligned-redirect reporting and a saturating fetch counter.
module pc_fetch_register
    import pc_fetch_register_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned      STEP     = DEFAULT_STEP,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic transfer;
    logic misaligned;
    logic redirect_ok;

    assign transfer    = (state_q == ISSUE) & req_ready;
    assign redirect_ok = redirect_valid & ~misaligned;

    pc_next_calc #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next_calc (
        .pc              (pc_q),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .transfer        (transfer),
        .next_pc         (pc_d),
        .misaligned      (misaligned)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        misalign_d = misaligned;

        // A transfer always counts, even when a redirect lands in the same cycle
        if (transfer && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end

        if (redirect_ok) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                ISSUE: begin
                    if (transfer && stall) begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = stall ? HOLD : ISSUE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign req_valid    = (state_q == ISSUE);
    assign pc           = pc_q;
    assign pc_plus_step = pc_q + WIDTH'(STEP);
    assign misalign_err = misalign_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_pc_fetch_register.sv
// Directed bench for pc_fetch_register; a second instance with a 4-bit counter covers saturation.
module tb_pc_fetch_register;

    logic        CLK;
    logic        RST_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        req_ready;

    logic        req_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus_step;
    logic        misalign_err;
    logic [15:0] fetch_count;

    logic        s_req_valid;
    logic [31:0] s_pc;
    logic [31:0] s_pc_plus_step;
    logic        s_misalign_err;
    logic [3:0]  s_fetch_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    pc_fetch_register dut (
        .CLK             (CLK),
        .RST_n           (RST_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .pc              (pc),
        .pc_plus_step    (pc_plus_step),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count)
    );

    pc_fetch_register #(
        .CNT_W (4)
    ) dut_sat (
        .CLK             (CLK),
        .RST_n           (RST_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .req_valid       (s_req_valid),
        .req_ready       (req_ready),
        .pc              (s_pc),
        .pc_plus_step    (s_pc_plus_step),
        .misalign_err    (s_misalign_err),
        .fetch_count     (s_fetch_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic v, input logic [31:0] p, input int unsigned c);
        chk({tag, ".req_valid"}, {31'd0, req_valid}, {31'd0, v});
        chk({tag, ".pc"}, pc, p);
        chk({tag, ".count"}, {16'd0, fetch_count}, c);
    endtask

    initial begin
        RST_n           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        req_ready       = 1'b1;

        // T1: reset for three edges, then sequential fetching
        tick();
        chk_main("rst1", 1'b0, 32'h0, 0);
        chk("rst1.misalign", {31'd0, misalign_err}, 32'd0);
        tick();
        tick();
        chk_main("rst3", 1'b0, 32'h0, 0);
        RST_n = 1'b1;
        tick();
        chk_main("boot_exit", 1'b1, 32'h0, 0);
        chk("boot_exit.pc_plus", pc_plus_step, 32'h4);
        tick();
        chk_main("seq1", 1'b1, 32'h4, 1);
        tick();
        chk_main("seq2", 1'b1, 32'h8, 2);
        tick();
        chk_main("seq3", 1'b1, 32'hC, 3);
        chk("seq3.sat_cnt", {28'd0, s_fetch_count}, 32'd3);

        // T2: backpressure holds request and address
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_main($sformatf("bp%0d", i), 1'b1, 32'hC, 3);
        end

        // T3: aligned redirect together with a transfer
        req_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        tick();
        chk_main("redir", 1'b0, 32'h100, 4);
        redirect_valid = 1'b0;
        tick();
        chk_main("flush_exit", 1'b1, 32'h100, 4);
        tick();
        chk_main("post_redir", 1'b1, 32'h104, 5);

        // T4: misaligned redirect is ignored and pulses the error
        req_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        tick();
        chk_main("misal", 1'b1, 32'h104, 5);
        chk("misal.err", {31'd0, misalign_err}, 32'd1);
        redirect_valid = 1'b0;
        tick();
        chk_main("misal_after", 1'b1, 32'h104, 5);
        chk("misal_after.err", {31'd0, misalign_err}, 32'd0);

        // T5: stall during an open request takes effect after the transfer
        stall     = 1'b1;
        req_ready = 1'b1;
        tick();
        chk_main("stall_xfer", 1'b0, 32'h108, 6);
        tick();
        chk_main("hold", 1'b0, 32'h108, 6);
        stall = 1'b0;
        tick();
        chk_main("hold_exit", 1'b1, 32'h108, 6);

        // T6: wrap at the top of the address space
        req_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        chk_main("wrap_redir", 1'b0, 32'hFFFF_FFFC, 6);
        redirect_valid = 1'b0;
        tick();
        chk_main("wrap_issue", 1'b1, 32'hFFFF_FFFC, 6);
        chk("wrap.pc_plus", pc_plus_step, 32'h0);
        req_ready = 1'b1;
        tick();
        chk_main("wrap", 1'b1, 32'h0, 7);
        tick();
        chk_main("wrap_next", 1'b1, 32'h4, 8);

        // Saturation of the 4-bit counter instance
        for (int i = 0; i < 7; i++) tick();
        chk_main("pre_sat", 1'b1, 32'h20, 15);
        chk("pre_sat.sat_cnt", {28'd0, s_fetch_count}, 32'd15);
        redirect_valid  = 1'b1;
        redirect_target = 32'h3;
        tick();
        chk_main("misal_xfer", 1'b1, 32'h24, 16);
        chk("misal_xfer.err", {31'd0, misalign_err}, 32'd1);
        chk("sat1.sat_cnt", {28'd0, s_fetch_count}, 32'd15);
        redirect_valid = 1'b0;
        tick();
        chk_main("sat2", 1'b1, 32'h28, 17);
        chk("sat2.err", {31'd0, misalign_err}, 32'd0);
        chk("sat2.sat_cnt", {28'd0, s_fetch_count}, 32'd15);

        // T7: reset in the middle of an outstanding request
        req_ready = 1'b0;
        RST_n     = 1'b0;
        tick();
        chk_main("midrst", 1'b0, 32'h0, 0);
        chk("midrst.err", {31'd0, misalign_err}, 32'd0);
        chk("midrst.sat_cnt", {28'd0, s_fetch_count}, 32'd0);
        RST_n     = 1'b1;
        req_ready = 1'b1;
        tick();
        chk_main("midrst_boot", 1'b1, 32'h0, 0);
        tick();
        chk_main("midrst_run", 1'b1, 32'h4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
